// File: rtl/uart_tx.sv
// uart_tx: UART transmitter framing start, LSB-first data, optional parity and stop bits on baud rises.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (PARITY_ODD picks odd parity).
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk50,
    input  logic                 reset,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;
    logic baud_q, baud_rise;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic ready_q, ready_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign baud_rise = baud & ~baud_q;
    assign tx_ready  = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q == IDLE) begin
            if (tx_valid && ready_q) begin
                state_d = ALIGN;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
            end
        end else if (baud_rise) begin
            // Every post-accept transition is paced by a baud rising edge.
            case (state_q)
                ALIGN: begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
                START: begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                        stop_cnt_d = '0;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end
`endif
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end
endmodule
